// File: rtl/mips_cpu_pc_unit_pkg.sv
// mips_cpu_pkg: types and constants shared by the program-counter stage.
//   pc_state_t           - RUN / DELAY / HALTED control state
//   RESET_VECTOR_DEFAULT - boot fetch address
//   HALT_ADDR_DEFAULT    - redirect address that halts the core
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

endpackage

// File: rtl/mips_cpu_pc_unit_if.sv
// mips_cpu_pc_unit_if: control-flow bus between decode/ALU and the PC stage.
//   master: drives stall, branch, zero, branch_offset, jump, jump_target,
//           jump_reg, jump_reg_addr; observes pc, link_addr, delay_slot, active
//   slave : the PC stage (opposite directions)
// Optional macro MIPS_PC_ALIGN_CHECK_EN adds the addr_error signal.
interface mips_cpu_pc_unit_if;

  logic        stall;
  logic        branch;
  logic        zero;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jump_reg;
  logic [31:0] jump_reg_addr;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        delay_slot;
  logic        active;
`ifdef MIPS_PC_ALIGN_CHECK_EN
  logic        addr_error;
`endif

  modport master (
    output stall, branch, zero, branch_offset, jump, jump_target,
           jump_reg, jump_reg_addr,
`ifdef MIPS_PC_ALIGN_CHECK_EN
    input  addr_error,
`endif
    input  pc, link_addr, delay_slot, active
  );

  modport slave (
    input  stall, branch, zero, branch_offset, jump, jump_target,
           jump_reg, jump_reg_addr,
`ifdef MIPS_PC_ALIGN_CHECK_EN
    output addr_error,
`endif
    output pc, link_addr, delay_slot, active
  );

endinterface

// File: rtl/mips_cpu_pc_target.sv
// mips_cpu_pc_target: combinational redirect target computation.
//   pc                       - current fetch address
//   branch/zero/branch_offset- conditional branch (taken when branch & zero)
//   jump/jump_target         - J/JAL instr_index
//   jump_reg/jump_reg_addr   - JR/JALR rs value
//   redirect                 - a control transfer is requested
//   target                   - selected target (jump_reg > jump > branch)
module mips_cpu_pc_target (
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic        zero,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_addr,
  output logic        redirect,
  output logic [31:0] target
);

  logic [31:0] pc4;
  logic [31:0] br_target;
  logic [31:0] j_target;

  always_comb begin
    pc4       = pc + 32'd4;
    // Sign-extended word offset, relative to the delay-slot address.
    br_target = pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    j_target  = {pc4[31:28], jump_target, 2'b00};

    redirect = 1'b0;
    target   = pc4;
    if (jump_reg) begin
      redirect = 1'b1;
      target   = jump_reg_addr;
    end else if (jump) begin
      redirect = 1'b1;
      target   = j_target;
    end else if (branch && zero) begin
      redirect = 1'b1;
      target   = br_target;
    end
  end

endmodule

// File: rtl/mips_cpu_pc_unit.sv
// mips_cpu_pc_unit: program counter with one branch delay slot and halt
// detection.
//   clk, reset - single clock, asynchronous active-high reset
//   bus        - mips_cpu_pc_unit_if.slave (control inputs, pc/link_addr/
//                delay_slot/active outputs)
// Parameters: RESET_VECTOR (pc after reset), HALT_ADDR (redirect target that
// halts the core after its delay slot).
// Optional macro MIPS_PC_ALIGN_CHECK_EN: misaligned redirect targets set a
// sticky addr_error and halt at once without executing the delay slot.
module mips_cpu_pc_unit
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input logic                 clk,
  input logic                 reset,
  mips_cpu_pc_unit_if.slave   bus
);

  pc_state_t   state, state_n;
  logic [31:0] pc_r, pc_n;
  logic [31:0] pending, pending_n;
  logic        redirect;
  logic [31:0] target;
`ifdef MIPS_PC_ALIGN_CHECK_EN
  logic        addr_error_r, addr_error_n;
`endif

  mips_cpu_pc_target u_target (
    .pc            (pc_r),
    .branch        (bus.branch),
    .zero          (bus.zero),
    .branch_offset (bus.branch_offset),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .jump_reg      (bus.jump_reg),
    .jump_reg_addr (bus.jump_reg_addr),
    .redirect      (redirect),
    .target        (target)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      pc_r    <= RESET_VECTOR;
      pending <= '0;
`ifdef MIPS_PC_ALIGN_CHECK_EN
      addr_error_r <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      pc_r    <= pc_n;
      pending <= pending_n;
`ifdef MIPS_PC_ALIGN_CHECK_EN
      addr_error_r <= addr_error_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc_r;
    pending_n = pending;
`ifdef MIPS_PC_ALIGN_CHECK_EN
    addr_error_n = addr_error_r;
`endif
    if (!bus.stall) begin
      unique case (state)
        RUN: begin
          if (redirect) begin
`ifdef MIPS_PC_ALIGN_CHECK_EN
            if (target[1:0] != 2'b00) begin
              addr_error_n = 1'b1;
              state_n      = HALTED;
            end else begin
              pending_n = target;
              pc_n      = pc_r + 32'd4;
              state_n   = DELAY;
            end
`else
            pending_n = target;
            pc_n      = pc_r + 32'd4;
            state_n   = DELAY;
`endif
          end else begin
            pc_n = pc_r + 32'd4;
          end
        end
        DELAY: begin
          pc_n    = pending;
          state_n = (pending == HALT_ADDR) ? HALTED : RUN;
        end
        HALTED: ;
        default: state_n = RUN;
      endcase
    end
  end

  assign bus.pc         = pc_r;
  assign bus.link_addr  = pc_r + 32'd8;
  assign bus.delay_slot = (state == DELAY);
  assign bus.active     = (state != HALTED);
`ifdef MIPS_PC_ALIGN_CHECK_EN
  assign bus.addr_error = addr_error_r;
`endif

endmodule

// File: tb/tb_mips_cpu_pc_unit.sv
module tb_mips_cpu_pc_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mips_cpu_pc_unit_if bus();

  mips_cpu_pc_unit #(
    .RESET_VECTOR (32'hBFC0_0000),
    .HALT_ADDR    (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        ds;
    logic        act;
  } exp_t;

  exp_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.stall         = 1'b0;
    bus.branch        = 1'b0;
    bus.zero          = 1'b0;
    bus.branch_offset = '0;
    bus.jump          = 1'b0;
    bus.jump_target   = '0;
    bus.jump_reg      = 1'b0;
    bus.jump_reg_addr = '0;
  endtask

  task automatic check_now(input string tag, input logic [31:0] epc,
                           input logic eds, input logic eact);
    check_eq({tag, ".pc"},   bus.pc, epc);
    check_eq({tag, ".link"}, bus.link_addr, epc + 32'd8);
    check_eq({tag, ".ds"},   {31'd0, bus.delay_slot}, {31'd0, eds});
    check_eq({tag, ".act"},  {31'd0, bus.active}, {31'd0, eact});
  endtask

  // Inputs are already driven; queue the expectation, clock once, compare.
  task automatic cycle(input string tag, input logic [31:0] epc,
                       input logic eds, input logic eact);
    exp_t e;
    e.tag = tag; e.pc = epc; e.ds = eds; e.act = eact;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_now(e.tag, e.pc, e.ds, e.act);
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_inputs();
    reset = 1'b1;
    #2;
    check_now("reset", 32'hBFC0_0000, 1'b0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Sequential fetch
    cycle("seq1", 32'hBFC0_0004, 1'b0, 1'b1);
    cycle("seq2", 32'hBFC0_0008, 1'b0, 1'b1);
    cycle("seq3", 32'hBFC0_000C, 1'b0, 1'b1);
    cycle("seq4", 32'hBFC0_0010, 1'b0, 1'b1);

    // Taken backward branch; branch held during delay slot is ignored
    bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_offset = 16'hFFFC;
    cycle("br_taken_ds", 32'hBFC0_0014, 1'b1, 1'b1);
    bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_offset = 16'h0100;
    cycle("br_taken_tgt", 32'hBFC0_0004, 1'b0, 1'b1);

    // Not-taken branch
    bus.branch = 1'b1; bus.zero = 1'b0; bus.branch_offset = 16'hFFFC;
    cycle("br_nt1", 32'hBFC0_0008, 1'b0, 1'b1);
    cycle("br_nt2", 32'hBFC0_000C, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      cycle("walk", 32'hBFC0_0010 + 32'(i) * 32'd4, 1'b0, 1'b1);

    // JR to HALT_ADDR: delay slot runs, then halted
    bus.jump_reg = 1'b1; bus.jump_reg_addr = 32'h0;
    cycle("halt_ds", 32'hBFC0_0024, 1'b1, 1'b1);
    cycle("halt_pc", 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.jump = 1'b1; bus.jump_target = 26'h0000040;
      cycle("halt_hold", 32'h0, 1'b0, 1'b0);
    end

    // Asynchronous reset out of HALTED
    #3; reset = 1'b1; #1;
    check_now("areset_halt", 32'hBFC0_0000, 1'b0, 1'b1);
    #1; reset = 1'b0;
    @(posedge clk); #1;
    check_now("post_reset_edge", 32'hBFC0_0004, 1'b0, 1'b1);
    reset = 1'b1; #1; reset = 1'b0; #1;
    check_now("reset_again", 32'hBFC0_0000, 1'b0, 1'b1);

    // JAL: link address while jump is current, then region jump
    bus.jump = 1'b1; bus.jump_target = 26'h0000040;
    #1;
    check_eq("jal_link", bus.link_addr, 32'hBFC0_0008);
    cycle("jal_ds", 32'hBFC0_0004, 1'b1, 1'b1);
    cycle("jal_tgt", 32'hB000_0100, 1'b0, 1'b1);

    // Stall throughout the delay slot
    bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_offset = 16'h0010;
    cycle("stall_ds", 32'hB000_0104, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1'b1;
      cycle("stall_hold", 32'hB000_0104, 1'b1, 1'b1);
    end
    cycle("stall_release", 32'hB000_0144, 1'b0, 1'b1);
    bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 26'h1;
    cycle("stall_run", 32'hB000_0144, 1'b0, 1'b1);

    // Reset mid-delay-slot drops the pending target
    bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_offset = 16'h0001;
    cycle("rst_ds", 32'hB000_0148, 1'b1, 1'b1);
    #3; reset = 1'b1; #1;
    check_now("areset_ds", 32'hBFC0_0000, 1'b0, 1'b1);
    #1; reset = 1'b0;
    cycle("pending_lost", 32'hBFC0_0004, 1'b0, 1'b1);

    // Priority: jump_reg over jump over branch
    bus.jump_reg = 1'b1; bus.jump_reg_addr = 32'h0000_1000;
    bus.jump = 1'b1; bus.jump_target = 26'h3FFFFFF;
    bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_offset = 16'h0040;
    cycle("prio_jr_ds", 32'hBFC0_0008, 1'b1, 1'b1);
    cycle("prio_jr_tgt", 32'h0000_1000, 1'b0, 1'b1);
    bus.jump = 1'b1; bus.jump_target = 26'h0000010;
    bus.branch = 1'b1; bus.zero = 1'b1; bus.branch_offset = 16'h0040;
    cycle("prio_j_ds", 32'h0000_1004, 1'b1, 1'b1);
    cycle("prio_j_tgt", 32'h0000_0040, 1'b0, 1'b1);

    // Misaligned register target
    bus.jump_reg = 1'b1; bus.jump_reg_addr = 32'h0040_0002;
`ifdef MIPS_PC_ALIGN_CHECK_EN
    cycle("align_halt", 32'h0000_0040, 1'b0, 1'b0);
    check_eq("align_err", {31'd0, bus.addr_error}, 32'd1);
    cycle("align_hold", 32'h0000_0040, 1'b0, 1'b0);
    check_eq("align_sticky", {31'd0, bus.addr_error}, 32'd1);
`else
    cycle("misalign_ds", 32'h0000_0044, 1'b1, 1'b1);
    cycle("misalign_tgt", 32'h0040_0002, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
